// File: rtl/vending_machine_if.sv
// ============================================================================
// Module      : vending_machine_if
// Description : Request/response bundle between a buyer and vending_machine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vending_machine_if;
    logic [1:0] Tag;
    logic [2:0] count;
    logic [3:0] money;
    logic       possibility;
    logic [3:0] remainingMoney;

    modport master (
        output Tag,
        output count,
        output money,
        input  possibility,
        input  remainingMoney
    );

    modport slave (
        input  Tag,
        input  count,
        input  money,
        output possibility,
        output remainingMoney
    );
endinterface

`default_nettype wire

// File: rtl/vending_machine.sv
// ============================================================================
// Module      : vending_machine
// Description : Evaluates a purchase each time the {Tag,count,money} tuple
//               changes; VM_STOCK_EN adds per-product stock counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_machine (
    input  wire logic          clk,
    input  wire logic          reset,
    vending_machine_if.slave   bus
);

    localparam logic [2:0] STOCK_INIT = 3'd7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] tag_q;
    logic [2:0] count_q;
    logic [3:0] money_q;
    logic       possibility_q;
    logic [3:0] remaining_q;

    logic [2:0] price;
    logic [4:0] cost;
    logic       stock_ok;
    logic       accept;
    logic       tuple_changed;
    logic [3:0] remaining_d;

    assign price         = {1'b0, bus.Tag} + 3'd1;
    assign cost          = {2'b00, price} * {2'b00, bus.count};
    assign tuple_changed = ({bus.Tag, bus.count, bus.money} != {tag_q, count_q, money_q});
    assign accept        = (bus.count != 3'd0) && ({1'b0, bus.money} >= cost) && stock_ok;
    // cost[4] is necessarily 0 whenever accept holds, so the low nibble is exact
    assign remaining_d   = accept ? (bus.money - cost[3:0]) : bus.money;

`ifdef VM_STOCK_EN
    logic [2:0] stock_q [4];

    assign stock_ok = (bus.count <= stock_q[bus.Tag]);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= STOCK_INIT;
            end
        end else if (tuple_changed && accept) begin
            stock_q[bus.Tag] <= stock_q[bus.Tag] - bus.count;
        end
    end
`else
    assign stock_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tag_q         <= 2'd0;
            count_q       <= 3'd0;
            money_q       <= 4'd0;
            possibility_q <= 1'b0;
            remaining_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE, EVAL: begin
                    if (tuple_changed) begin
                        state_q       <= EVAL;
                        tag_q         <= bus.Tag;
                        count_q       <= bus.count;
                        money_q       <= bus.money;
                        possibility_q <= accept;
                        remaining_q   <= remaining_d;
                    end else begin
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.possibility    = possibility_q;
    assign bus.remainingMoney = remaining_q;

endmodule

`default_nettype wire

// File: tb/tb_vending_machine.sv
// ============================================================================
// Module      : tb_vending_machine
// Description : Directed and random stimulus against a behavioural purchase model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vending_machine;

    logic clk;
    logic reset;
    vending_machine_if bus ();

    vending_machine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: last evaluated tuple, outputs, stock per product
    int m_tag, m_cnt, m_mon;
    int m_poss, m_rem;
    int m_stock [4];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int t, input int c, input int m, input bit r);
        int cost;
        bit ok;
        if (r) begin
            m_tag = 0; m_cnt = 0; m_mon = 0;
            m_poss = 0; m_rem = 0;
            for (int i = 0; i < 4; i++) m_stock[i] = 7;
        end else if (t != m_tag || c != m_cnt || m != m_mon) begin
            cost = (t + 1) * c;
            ok = (c != 0) && (m >= cost);
`ifdef VM_STOCK_EN
            ok = ok && (c <= m_stock[t]);
`endif
            m_poss = ok ? 1 : 0;
            m_rem  = ok ? (m - cost) : m;
            if (ok) m_stock[t] = m_stock[t] - c;
            m_tag = t; m_cnt = c; m_mon = m;
        end
    endtask

    task automatic step(input int t, input int c, input int m, input bit r, input string tag);
        bus.Tag   = 2'(t);
        bus.count = 3'(c);
        bus.money = 4'(m);
        reset     = r;
        @(posedge clk);
        model_edge(t, c, m, r);
        #1;
        check({tag, "_poss"}, int'(bus.possibility), m_poss);
        check({tag, "_rem"},  int'(bus.remainingMoney), m_rem);
    endtask

    initial begin
        int t, c, m;
        bit r;
        bus.Tag = 2'd0; bus.count = 3'd0; bus.money = 4'd0; reset = 1'b1;
        m_tag = 0; m_cnt = 0; m_mon = 0; m_poss = 0; m_rem = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 7;

        step(0, 0, 0, 1'b1, "reset");
        check("reset_poss_const", int'(bus.possibility), 0);
        check("reset_rem_const",  int'(bus.remainingMoney), 0);
        step(0, 0, 0, 1'b0, "zero_tuple");
        check("zero_tuple_const", int'(bus.remainingMoney), 0);

        step(3, 2, 8, 1'b0, "t3c2m8");
        check("exact_pay_poss", int'(bus.possibility), 1);
        check("exact_pay_rem",  int'(bus.remainingMoney), 0);
        for (int i = 0; i < 5; i++) step(3, 2, 8, 1'b0, "hold");
        check("hold_poss", int'(bus.possibility), 1);

        step(0, 1, 5, 1'b0, "t0c1m5");
        check("change_rem", int'(bus.remainingMoney), 4);
        step(2, 3, 8, 1'b0, "t2c3m8");
        check("short_poss", int'(bus.possibility), 0);
        check("short_rem",  int'(bus.remainingMoney), 8);
        step(1, 0, 15, 1'b0, "count0");
        check("count0_poss", int'(bus.possibility), 0);
        check("count0_rem",  int'(bus.remainingMoney), 15);

        step(1, 7, 15, 1'b0, "t1c7");
        check("t1c7_rem", int'(bus.remainingMoney), 1);
        step(1, 1, 14, 1'b0, "t1c1");
`ifdef VM_STOCK_EN
        check("sold_out_rem", int'(bus.remainingMoney), 14);
`else
        check("unlimited_rem", int'(bus.remainingMoney), 12);
`endif

        step(3, 1, 9, 1'b1, "reset_collide");
        check("collide_poss", int'(bus.possibility), 0);
        check("collide_rem",  int'(bus.remainingMoney), 0);
        step(3, 1, 9, 1'b0, "post_reset");
        check("post_reset_rem", int'(bus.remainingMoney), 5);
        step(3, 3, 15, 1'b0, "t3c3");

        t = 0; c = 0; m = 0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) >= 30) begin
                t = $urandom_range(0, 3);
                c = $urandom_range(0, 7);
                m = $urandom_range(0, 15);
            end
            step(t, c, m, r, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: Tag  input  2  product select (0..3).
REQ-004 SHALL have: count  input  3  requested quantity (0..7).
REQ-005 SHALL have: money  input  4  inserted amount (0..15 units).
REQ-006 SHALL have: possibility  output  1  registered; 1 = last transaction accepted.
REQ-007 SHALL have: remainingMoney  output  4  registered; change or refund of last transaction.

Function
REQ-008 Unit price SHALL be fixed: Tag 0 = 1, Tag 1 = 2, Tag 2 = 3, Tag 3 = 4.
REQ-009 Cost SHALL be price x count, computed at 5 bits (max 28), with no truncation; comparison against money SHALL be made with money zero-extended to 5 bits.
REQ-010 The block SHALL register the last evaluated tuple {Tag, count, money}; a transaction SHALL start on any rising edge where the current input tuple differs from the registered tuple.
REQ-011 Tuple held unchanged SHALL NOT start a new transaction; outputs and stock SHALL hold.
REQ-012 Latency: outputs SHALL reflect a transaction at the same rising edge that samples the changed tuple (one-cycle registered latency from input change).
REQ-013 Accept condition: count != 0, money >= cost, and (if stock enabled) count <= stock[Tag].
REQ-014 On accept: possibility = 1, remainingMoney = money - cost (exact, 0..15).
REQ-015 On reject: possibility = 0, remainingMoney = money (full refund).
REQ-016 count = 0 SHALL always reject.
REQ-017 money == cost SHALL accept with remainingMoney = 0.
REQ-018 Internal states: IDLE (holding outputs), EVAL (tuple change detected, single edge); EVAL SHALL return to IDLE on the next edge unless the tuple changes again, in which case EVAL repeats.

Reset
REQ-019 On reset high at a rising edge: possibility = 0, remainingMoney = 0, registered tuple = {0,0,0}, state = IDLE, every stock counter = 7.
REQ-020 Reset SHALL take priority over a simultaneous transaction; no stock change SHALL occur on that edge.
REQ-021 After reset release, a tuple of {0,0,0} SHALL NOT trigger a transaction; any other tuple SHALL.

Configuration
REQ-022 Macro VM_STOCK_EN SHALL compile in per-product stock tracking.
REQ-023 With VM_STOCK_EN defined: four 3-bit stock counters; accept requires count <= stock[Tag]; on accept stock[Tag] decreases by count (never below 0); other products unchanged.
REQ-024 Without VM_STOCK_EN: no stock counters; stock is unlimited; accept depends only on count and money.

Verification
REQ-025 Reset asserted one edge -> possibility 0, remainingMoney 0; inputs {0,0,0} after release -> outputs stay 0.
REQ-026 Tag 3, count 2, money 8 -> next edge possibility 1, remainingMoney 0; held 5 cycles -> outputs and stock[3]=5 unchanged.
REQ-027 Tag 0, count 1, money 5 -> possibility 1, remainingMoney 4; then Tag 2, count 3, money 8 (cost 9) -> possibility 0, remainingMoney 8.
REQ-028 Tag 1, count 0, money 15 -> possibility 0, remainingMoney 15.
REQ-029 VM_STOCK_EN: Tag 1, count 7, money 15 -> possibility 1, remainingMoney 1, stock[1]=0; then Tag 1, count 1, money 14 -> possibility 0, remainingMoney 14; without macro the second request -> possibility 1, remainingMoney 12.
REQ-030 Reset asserted on the same edge as a changed tuple Tag 3, count 1, money 9 -> outputs 0, stock[3]=7.
